multi_channel_timer: RTL

- Parametrised successor of the single-channel fixed-start down-counter used for periodic SoC housekeeping, e.g. CAN node status/heartbeat ticks.
- Provides NUM_CH independent down-counting channels behind one shared clock prescaler.
- Each channel has a runtime-loadable reload value, per-channel enable, periodic or one-shot mode, a single-cycle expiry pulse, and a sticky, clearable IRQ flag.
- Sits between the CPU peripheral register decode (drives strobes/values) and the interrupt aggregator.

---
 rtl/multi_channel_timer.sv | 99 +++++++++
 1 files changed

// File: rtl/multi_channel_timer.sv
// Multi-channel down-counting timer behind a shared prescaler.
// Each channel has a loadable reload value, periodic/one-shot mode, an expiry pulse and a sticky IRQ.
module multi_channel_timer #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned PRESC_W      = 16,
  parameter logic [31:0] RESET_RELOAD = 32'd0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [PRESC_W-1:0]                            prescale_div,
  input  logic [NUM_CH-1:0]                             ch_en,
  input  logic [NUM_CH-1:0]                             ch_periodic,
  input  logic [NUM_CH-1:0]                             load,
  input  logic [NUM_CH*WIDTH-1:0]                       load_val,
  input  logic [NUM_CH-1:0]                             irq_clr,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] count_sel,
  output logic [NUM_CH-1:0]                             expire,
  output logic [NUM_CH-1:0]                             irq,
  output logic [NUM_CH-1:0]                             active,
  output logic [WIDTH-1:0]                              count_out
);

  localparam logic [WIDTH-1:0] RST_RELOAD = WIDTH'(RESET_RELOAD);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;
  logic [WIDTH-1:0]   cnt [NUM_CH];

  assign tick = (presc_cnt == '0);

  // prescale_div is only picked up when the divider wraps, so a new value
  // never shortens or stretches the period already in progress
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= prescale_div;
    end else begin
      presc_cnt <= presc_cnt - PRESC_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] rld_q;
    logic             act_q;
    logic             irq_q;
    logic             exp_q;
    logic             terminal;

    // a load in the same cycle as the terminal tick wins and suppresses expiry
    assign terminal = !load[g] && act_q && ch_en[g] && tick && (cnt_q == '0);

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q <= '0;
        rld_q <= RST_RELOAD;
        act_q <= 1'b0;
        irq_q <= 1'b0;
        exp_q <= 1'b0;
      end else begin
        exp_q <= terminal;
        if (load[g]) begin
          cnt_q <= load_val[g*WIDTH +: WIDTH];
          rld_q <= load_val[g*WIDTH +: WIDTH];
          act_q <= 1'b1;
        end else if (terminal) begin
          if (ch_periodic[g]) begin
            cnt_q <= rld_q;
          end else begin
            act_q <= 1'b0;
          end
        end else if (act_q && ch_en[g] && tick) begin
          cnt_q <= cnt_q - WIDTH'(1);
        end

        if (terminal) begin
          irq_q <= 1'b1;
        end else if (irq_clr[g]) begin
          irq_q <= 1'b0;
        end
      end
    end

    assign cnt[g]    = cnt_q;
    assign active[g] = act_q;
    assign irq[g]    = irq_q;
    assign expire[g] = exp_q;
  end

  always_comb begin
    count_out = '0;
    if (32'(count_sel) < NUM_CH) begin
      count_out = cnt[count_sel];
    end
  end

endmodule
